swipt_link_ctrl: RTL and testbench
==================================

Name: swipt_link_ctrl

Overview:
- Parametrised bit-serial frame link controller for the SWIPT downlink: it serialises one command frame, then opens a blanked receive window and waits for the answer.
- It generalises the fixed 36-bit link with configurable field widths, bit period, blanking and timeout.
- New behaviour over the fixed link: automatic retransmission on timeout or bad checksum, and a reported completion status.
- Sits between the register/host interface and the receive analyser, which supplies rx_ready/rx_ok.

Parameters:
DATA_W, 16, payload width in bits
MODE_W, 2, mode field width
TYPE_W, 2, type field width
BIT_PERIOD, 200000, clk cycles per transmitted bit (>=1)
BLIND_CYCLES, 1000000, cycles after TX end during which rx is ignored
TIMEOUT_CYCLES, 10000000, cycles from TX end to give up (> BLIND_CYCLES)
MAX_RETRIES, 3, retransmissions allowed after the first attempt
CNT_W, 24, timer width; must hold max(BIT_PERIOD, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
nrst  in  1  reset; asynchronous, active-low
enable  in  1  link allowed; equals swiptAlive AND program==2'b11 at top level
start  in  1  request a transaction; sampled in IDLE only
mode_in  in  MODE_W  mode field
type_in  in  TYPE_W  type field
data_in  in  DATA_W  payload
rx_ready  in  1  single-cycle pulse from analyser: answer frame decoded
rx_ok  in  1  analyser checksum valid; qualified by rx_ready
dout  out  1  serial line to modulator
tx_active  out  1  high while in TX
rx_listen  out  1  high in LISTEN; enables receive chain
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on transaction completion
status  out  2  00 ok, 01 timeout, 10 bad checksum; valid from done onwards
retries_used  out  2  retransmissions performed in the last transaction (saturates at 3)

Behaviour:
- Reset (nrst=0, async): state IDLE; dout, tx_active, rx_listen, busy, done=0; status=00; retries_used=0; all counters 0.
- Frame: F = 12 + 2*(MODE_W+TYPE_W) + DATA_W bits, sent in this order:
  - Preamble 101010.
  - Mode bits, MSB first, each sent as the pair (~b, b).
  - Type bits, MSB first, each sent as the pair (~b, b).
  - Payload, MSB first.
  - Parity pair (~p, p), where p = XOR of the payload.
  - Trailer 0101.
- Default F = 36.
- Field latch: mode_in, type_in and data_in are latched on accepted start. Retries resend the latched frame.
- IDLE: on start=1 and enable=1, latch the fields, set retries_used=0, and enter TX on the next cycle. start is ignored in every other state.
- TX:
  - The first bit appears on dout in the first TX cycle.
  - Each bit is held exactly BIT_PERIOD cycles.
  - tx_active=1 throughout.
  - After F*BIT_PERIOD cycles: dout=0 and enter BLIND.
- BLIND:
  - rx_listen=0.
  - rx_ready is ignored.
  - The timeout counter starts at entry.
  - After BLIND_CYCLES cycles, enter LISTEN.
- LISTEN: rx_listen=1. Priority per cycle:
  - 1. rx_ready & rx_ok: DONE with status=00.
  - 2. rx_ready & ~rx_ok: retry if retries_used<MAX_RETRIES, else DONE with status=10.
  - 3. Timeout counter reaches TIMEOUT_CYCLES (counted from BLIND entry): retry if allowed, else DONE with status=01.
  - rx_ready coinciding with timeout: rx_ready wins.
- Retry:
  - retries_used increments.
  - Next cycle enters TX from bit 0 of the latched frame.
  - rx_listen drops in the same cycle the retry is decided.
- DONE: one cycle. done=1, busy=1, then IDLE. status and retries_used hold until the next accepted start.
- enable=0 in any state (synchronous abort): next cycle is IDLE, with dout=0, tx_active=0 and rx_listen=0. No done pulse; status unchanged.
- Counters never wrap. The bit index and timers are cleared on every TX/BLIND entry.

Test Plan:
- Frame content and timing:
  - Stimulus: BIT_PERIOD=4, mode=2'b11, type=2'b01, data=16'hA5F0, start pulse.
  - Required: dout sequence 101010 0101 1001 1010010111110000 10 0101, each bit 4 cycles, tx_active high for exactly 144 cycles.
- Successful answer:
  - Stimulus: BLIND_CYCLES=10, TIMEOUT_CYCLES=50; rx_ready & rx_ok 5 cycles into BLIND, then again 3 cycles into LISTEN.
  - Required: the first pulse is ignored; the second gives done with status=00 and retries_used=0.
- Bad checksum and retries:
  - Stimulus: MAX_RETRIES=3; rx_ready & ~rx_ok in every LISTEN.
  - Required: 4 complete TX frames, then done with status=10 and retries_used=3.
- Timeout and race:
  - Stimulus: no rx_ready; done should follow 4 attempts. On a second run, rx_ready & rx_ok in the exact timeout cycle.
  - Required: first run ends with status=01 and retries_used=3. Second run ends with status=00 and no retry.
- Abort and reset:
  - Stimulus: enable=0 mid-TX. In a separate run, nrst=0 mid-LISTEN.
  - Required:
    - Abort: IDLE next cycle, dout=0, no done.
    - Reset: all outputs 0 asynchronously (before the next clk edge).
- Start handling:
  - Stimulus: start held high while busy; start=1 while enable=0.
  - Required: neither starts a transaction, and the latched data does not change.

Source files
------------

// File: rtl/swipt_link_ctrl.sv
// swipt_link_ctrl: bit-serial frame link controller for the SWIPT downlink.
// Sends one command frame, waits out a blanking window, then listens for the answer.
// A timeout or a bad checksum triggers a retransmission of the same frame.
// Once the retries run out, the transaction completes with a status code.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   enable               link allowed; dropping it aborts to idle on the next cycle
//   start                transaction request, sampled only in idle
//   mode_in/type_in/data_in  frame fields, latched on an accepted start
//   rx_ready, rx_ok      answer-decoded pulse and checksum-valid flag from the analyser
//   dout                 serial line to the modulator
//   tx_active            high while the frame is being sent
//   rx_listen            high while the receive window is open
//   busy                 high in every state except idle
//   done                 one-cycle completion pulse
//   status               00 ok, 01 timeout, 10 bad checksum
//   retries_used         retransmissions in the last transaction, saturating at 3
module swipt_link_ctrl #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned MODE_W         = 2,
  parameter int unsigned TYPE_W         = 2,
  parameter int unsigned BIT_PERIOD     = 200000,
  parameter int unsigned BLIND_CYCLES   = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 24
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              start,
  input  logic [MODE_W-1:0] mode_in,
  input  logic [TYPE_W-1:0] type_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rx_ready,
  input  logic              rx_ok,
  output logic              dout,
  output logic              tx_active,
  output logic              rx_listen,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [1:0]        retries_used
);

  localparam int unsigned FrameW = 12 + 2 * (MODE_W + TYPE_W) + DATA_W;
  localparam int unsigned IdxW   = $clog2(FrameW);
  localparam int unsigned RtryW  = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {StIdle, StTx, StBlind, StListen, StDone} state_e;

  state_e              state_q;
  logic [FrameW-1:0]   frame_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [IdxW-1:0]     bit_idx_q;
  logic [CNT_W-1:0]    tmr_q;
  logic [RtryW-1:0]    retry_q;

  logic [FrameW-1:0]   frame_in;
  logic [IdxW-1:0]     next_pos;
  logic                retry_ok;
  logic                timeout;

  // Frame is sent MSB first: preamble, mode pairs, type pairs, payload, parity pair, trailer.
  function automatic logic [FrameW-1:0] build_frame(input logic [MODE_W-1:0] m,
                                                    input logic [TYPE_W-1:0] t,
                                                    input logic [DATA_W-1:0] d);
    logic [2*MODE_W-1:0] mp;
    logic [2*TYPE_W-1:0] tp;
    logic                p;
    for (int i = 0; i < int'(MODE_W); i++) begin
      mp[2*i+1] = ~m[i];
      mp[2*i]   = m[i];
    end
    for (int i = 0; i < int'(TYPE_W); i++) begin
      tp[2*i+1] = ~t[i];
      tp[2*i]   = t[i];
    end
    p = ^d;
    return {6'b101010, mp, tp, d, ~p, p, 4'b0101};
  endfunction

  always_comb begin
    frame_in = build_frame(mode_in, type_in, data_in);
    // Frame bit position of the next bit to drive; only used when bit_idx_q < FrameW-1.
    next_pos = IdxW'(FrameW - 2) - bit_idx_q;
    retry_ok = retry_q < RtryW'(MAX_RETRIES);
    timeout  = tmr_q == CNT_W'(TIMEOUT_CYCLES - 1);
  end

  always_comb begin
    if (32'(retry_q) > 32'd3) retries_used = 2'd3;
    else                      retries_used = 2'(retry_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tmr_q     <= '0;
      retry_q   <= '0;
      dout      <= 1'b0;
      tx_active <= 1'b0;
      rx_listen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= 2'b00;
    end else if (!enable) begin
      // Synchronous abort: status and the latched frame are left untouched.
      state_q   <= StIdle;
      dout      <= 1'b0;
      tx_active <= 1'b0;
      rx_listen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StTx;
            frame_q   <= frame_in;
            retry_q   <= '0;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            busy      <= 1'b1;
            tx_active <= 1'b1;
            dout      <= frame_in[FrameW-1];
          end
        end
        StTx: begin
          if (bit_cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == IdxW'(FrameW - 1)) begin
              state_q   <= StBlind;
              dout      <= 1'b0;
              tx_active <= 1'b0;
              tmr_q     <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + IdxW'(1);
              dout      <= frame_q[next_pos];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        StBlind: begin
          // tmr_q keeps running into LISTEN so the timeout counts from blind entry.
          tmr_q <= tmr_q + CNT_W'(1);
          if (tmr_q == CNT_W'(BLIND_CYCLES - 1)) begin
            state_q   <= StListen;
            rx_listen <= 1'b1;
          end
        end
        StListen: begin
          if (rx_ready && rx_ok) begin
            state_q   <= StDone;
            rx_listen <= 1'b0;
            done      <= 1'b1;
            status    <= 2'b00;
          end else if (rx_ready || timeout) begin
            rx_listen <= 1'b0;
            if (retry_ok) begin
              state_q   <= StTx;
              retry_q   <= retry_q + RtryW'(1);
              bit_cnt_q <= '0;
              bit_idx_q <= '0;
              tx_active <= 1'b1;
              dout      <= frame_q[FrameW-1];
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              status  <= rx_ready ? 2'b10 : 2'b01;
            end
          end else begin
            tmr_q <= tmr_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swipt_link_ctrl.sv
// Self-checking bench for swipt_link_ctrl with short bit period and windows.
module tb_swipt_link_ctrl;

  localparam int BP   = 4;
  localparam int BLND = 10;
  localparam int TMO  = 50;
  localparam int FLEN = 36;

  localparam int PolOk    = 0;
  localparam int PolBad   = 1;
  localparam int PolNone  = 2;
  localparam int PolRace  = 3;
  localparam int PolBadOk = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_in = '0;
  logic [1:0]  type_in = '0;
  logic [15:0] data_in = '0;
  logic        rx_ready = 1'b0;
  logic        rx_ok = 1'b0;
  logic        dout, tx_active, rx_listen, busy, done;
  logic [1:0]  status, retries_used;

  swipt_link_ctrl #(
    .DATA_W(16), .MODE_W(2), .TYPE_W(2), .BIT_PERIOD(BP), .BLIND_CYCLES(BLND),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(3), .CNT_W(24)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .start(start), .mode_in(mode_in),
    .type_in(type_in), .data_in(data_in), .rx_ready(rx_ready), .rx_ok(rx_ok),
    .dout(dout), .tx_active(tx_active), .rx_listen(rx_listen), .busy(busy), .done(done),
    .status(status), .retries_used(retries_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  typ;
    logic [15:0] data;
    logic [35:0] frame;
    int          policy;
    logic [1:0]  st;
    logic [1:0]  rt;
    int          frames;
    bit          hold;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [1:0] rt;
  } res_t;

  vec_t vecs[5];
  logic bitq[$];
  res_t resq[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   tx_run = 0;
  bit   expect_abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] model_frame(input logic [1:0] m, input logic [1:0] t,
                                              input logic [15:0] d);
    logic [35:0] f;
    logic        p;
    f = '0;
    p = 1'b0;
    for (int i = 0; i < 6; i++) f = {f[34:0], logic'(i % 2 == 0)};
    for (int i = 1; i >= 0; i--) f = {f[33:0], ~m[i], m[i]};
    for (int i = 1; i >= 0; i--) f = {f[33:0], ~t[i], t[i]};
    for (int i = 15; i >= 0; i--) begin
      f = {f[34:0], d[i]};
      p = p ^ d[i];
    end
    f = {f[33:0], ~p, p};
    f = {f[31:0], 4'b0101};
    return f;
  endfunction

  task automatic push_frame(input logic [35:0] f);
    for (int b = FLEN - 1; b >= 0; b--)
      for (int k = 0; k < BP; k++) bitq.push_back(f[b]);
  endtask

  // Monitor/scoreboard: pops one expected dout sample per TX cycle and one result per done.
  always @(negedge clk) begin
    if (tx_active) begin
      tx_run++;
      if (bitq.size() == 0) chk("tx_extra_cycle", 32'(dout), 32'hx);
      else chk("tx_bit", 32'(dout), 32'(bitq.pop_front()));
    end else begin
      if (tx_run != 0) begin
        if (!expect_abort) chk("tx_len", 32'(tx_run), 32'(FLEN * BP));
        tx_run = 0;
      end
      chk("idle_dout", 32'(dout), 32'd0);
    end
    if (done === 1'b1) begin
      res_t r;
      done_cnt++;
      if (resq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        r = resq.pop_front();
        chk("done_status", 32'(status), 32'(r.st));
        chk("done_retries", 32'(retries_used), 32'(r.rt));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_listen", 32'(rx_listen), 32'd0);
      end
    end
  end

  task automatic pulse(input logic ok);
    rx_ready = 1'b1;
    rx_ok    = ok;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_ok    = 1'b0;
  endtask

  // Returns at the negedge of the first BLIND cycle (tx_active just fell).
  task automatic wait_tx_fall(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && tx_active !== 1'b1; i++) @(negedge clk);
    if (tx_active !== 1'b1) begin
      chk("tx_rise_timeout", 32'(tx_active), 32'd1);
      return;
    end
    for (int i = 0; i < 200 && tx_active !== 1'b0; i++) @(negedge clk);
    if (tx_active !== 1'b0) chk("tx_fall_timeout", 32'(tx_active), 32'd0);
    else ok = 1;
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    bit ok;
    res_t r;
    base = done_cnt;
    for (int a = 0; a < v.frames; a++) push_frame(v.frame);
    r.st = v.st;
    r.rt = v.rt;
    resq.push_back(r);
    mode_in = v.mode;
    type_in = v.typ;
    data_in = v.data;
    start   = 1'b1;
    @(negedge clk);
    if (v.hold) begin
      mode_in = ~v.mode;
      type_in = ~v.typ;
      data_in = ~v.data;
    end else begin
      start = 1'b0;
    end
    for (int a = 0; a < v.frames; a++) begin
      wait_tx_fall(ok);
      if (!ok) break;
      chk("blind_listen_low", 32'(rx_listen), 32'd0);
      case (v.policy)
        PolOk: begin
          repeat (5) @(negedge clk);
          pulse(1'b1);
          repeat (7) @(negedge clk);
          chk("listen_high", 32'(rx_listen), 32'd1);
          pulse(1'b1);
        end
        PolBad: begin
          repeat (BLND) @(negedge clk);
          pulse(1'b0);
        end
        PolRace: begin
          repeat (TMO - 1) @(negedge clk);
          chk("race_listen", 32'(rx_listen), 32'd1);
          pulse(1'b1);
        end
        PolBadOk: begin
          repeat (BLND + 2) @(negedge clk);
          pulse(a == v.frames - 1);
        end
        default: ;
      endcase
    end
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_pulse", 32'(done), 32'd0);
    chk("status_hold", 32'(status), 32'(v.st));
    @(negedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'(base + 1));
  endtask

  initial begin
    bit ok;
    int base;
    vecs[0] = '{2'b11, 2'b01, 16'hA5F0, 36'b101010_0101_1001_1010010111110000_10_0101,
                PolOk, 2'b00, 2'd0, 1, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 16'h1234, '0, PolBad, 2'b10, 2'd3, 4, 1'b1};
    vecs[2] = '{2'b00, 2'b10, 16'h0001, '0, PolRace, 2'b00, 2'd0, 1, 1'b0};
    vecs[3] = '{2'b11, 2'b11, 16'h8000, '0, PolBadOk, 2'b00, 2'd1, 2, 1'b0};
    vecs[4] = '{2'b01, 2'b11, 16'hFFFF, '0, PolNone, 2'b01, 2'd3, 4, 1'b0};
    for (int i = 1; i < 5; i++) vecs[i].frame = model_frame(vecs[i].mode, vecs[i].typ, vecs[i].data);

    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_tx", 32'(tx_active), 32'd0);
    chk("rst_listen", 32'(rx_listen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_retries", 32'(retries_used), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort mid-TX: idle next cycle, no done, status keeps the timeout code.
    base = done_cnt;
    expect_abort = 1;
    push_frame(model_frame(2'b10, 2'b10, 16'h5A5A));
    mode_in = 2'b10; type_in = 2'b10; data_in = 16'h5A5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_tx", 32'(tx_active), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_listen", 32'(rx_listen), 32'd0);
    bitq.delete();
    // start while disabled must be ignored.
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("dis_start_busy", 32'(busy), 32'd0);
      chk("dis_start_tx", 32'(tx_active), 32'd0);
    end
    start = 1'b0;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(base));
    chk("abort_status", 32'(status), 32'd1);
    expect_abort = 0;

    // Asynchronous reset mid-LISTEN.
    push_frame(model_frame(2'b01, 2'b01, 16'h0F0F));
    mode_in = 2'b01; type_in = 2'b01; data_in = 16'h0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tx_fall(ok);
    repeat (BLND + 5) @(negedge clk);
    chk("pre_rst_listen", 32'(rx_listen), 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_listen", 32'(rx_listen), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_tx", 32'(tx_active), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_retries", 32'(retries_used), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    chk("bitq_empty", 32'(bitq.size()), 32'd0);
    chk("resq_empty", 32'(resq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
